pipe_elastic_chain: RTL and testbench

//  Parametrised, elastic pipeline register chain with valid/ready handshake, per-stage flush
//  and optional output skid buffer. Generalises the fixed IF/ID..MEM/WB stage buffers so that

---
 rtl/pipe_elastic_chain_pkg.sv | 9 +
 rtl/pipe_elastic_chain_skid.sv | 65 ++++++
 rtl/pipe_elastic_chain.sv | 124 ++++++++++++
 tb/tb_pipe_elastic_chain.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_elastic_chain_pkg.sv
// Shared constants and types for the elastic pipeline chain and its output skid buffer.
package pipe_elastic_chain_pkg;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

    typedef logic [SKID_CNT_W-1:0] skid_cnt_t;

endpackage

// File: rtl/pipe_elastic_chain_skid.sv
// Two-entry output skid buffer with a registered in_ready, so that out_ready never reaches
// upstream combinationally.
module pipe_elastic_chain_skid
    import pipe_elastic_chain_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output skid_cnt_t         count_nxt_c
);

    skid_cnt_t         count_q;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic              push;
    logic              pop;

    assign out_valid = (count_q != '0);
    assign out_data  = head_q;

    always_comb begin
        push        = in_valid & in_ready;
        pop         = out_ready & out_valid;
        count_nxt_c = count_q;
        if (reset || clear) begin
            count_nxt_c = '0;
        end else if (push && !pop) begin
            count_nxt_c = count_q + skid_cnt_t'(1);
        end else if (pop && !push) begin
            count_nxt_c = count_q - skid_cnt_t'(1);
        end
    end

    // head is the oldest entry; tail only ever holds the second item when head is stuck
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            in_ready <= 1'b1;
            head_q   <= '0;
            tail_q   <= '0;
        end else begin
            count_q  <= count_nxt_c;
            in_ready <= (count_nxt_c < skid_cnt_t'(SKID_DEPTH));
            if (!clear) begin
                if (push && ((count_q == '0) || ((count_q == skid_cnt_t'(1)) && pop))) begin
                    head_q <= in_data;
                end else if (pop && (count_q == skid_cnt_t'(SKID_DEPTH))) begin
                    head_q <= tail_q;
                end
                if (push && (count_q == skid_cnt_t'(1)) && !pop) begin
                    tail_q <= in_data;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_elastic_chain.sv
// Elastic valid/ready register chain with per-stage kill, global flush and optional output
// skid buffer; bubbles collapse so the chain sustains one item per cycle.
module pipe_elastic_chain
    import pipe_elastic_chain_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STAGES = 4,
    parameter bit          SKID   = 1'b0,
    localparam int unsigned OCC_W = $clog2(STAGES + 3)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [STAGES-1:0] flush,
    input  logic              flush_all,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [STAGES-1:0] stage_valid,
    output logic [OCC_W-1:0]  occupancy
);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_nxt;
    logic [STAGES-1:0] ev;
    logic [STAGES:0]   ready;
    logic [STAGES:0]   prev;
    logic [DATA_W-1:0] data_q   [STAGES];
    logic [DATA_W-1:0] data_src [STAGES];
    logic              tail_ready;
    skid_cnt_t         skid_cnt_nxt;
    logic [OCC_W-1:0]  occ_nxt;

    assign stage_valid = valid_q;

    // ready ripples back from the tail; prev[k] is the effective valid arriving at stage k
    always_comb begin
        ev             = valid_q & ~flush;
        ready          = '0;
        ready[STAGES]  = tail_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            ready[k] = ~ev[k] | ready[k+1];
        end
        in_ready  = ready[0] & ~flush_all & ~reset;
        prev      = {ev, in_valid};
        valid_nxt = valid_q;
        for (int k = 0; k < int'(STAGES); k++) begin
            if (ready[k]) begin
                valid_nxt[k] = prev[k];
            end
        end
        if (reset || flush_all) begin
            valid_nxt = '0;
        end
    end

    always_comb begin
        data_src[0] = in_data;
        for (int k = 1; k < int'(STAGES); k++) begin
            data_src[k] = data_q[k-1];
        end
    end

    always_comb begin
        occ_nxt = OCC_W'(skid_cnt_nxt);
        for (int k = 0; k < int'(STAGES); k++) begin
            occ_nxt = occ_nxt + OCC_W'(valid_nxt[k]);
        end
    end

    // data only moves when a live item arrives, so killed slots keep stale payload harmlessly
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            occupancy <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q   <= valid_nxt;
            occupancy <= occ_nxt;
            for (int k = 0; k < int'(STAGES); k++) begin
                if (!flush_all && ready[k] && prev[k]) begin
                    data_q[k] <= data_src[k];
                end
            end
        end
    end

    generate
        if (SKID) begin : g_skid
            logic              skid_in_ready;
            logic              skid_valid;
            logic [DATA_W-1:0] skid_data;

            pipe_elastic_chain_skid #(
                .DATA_W (DATA_W)
            ) u_skid (
                .clk         (clk),
                .reset       (reset),
                .clear       (flush_all),
                .in_valid    (ev[STAGES-1] & ~flush_all),
                .in_ready    (skid_in_ready),
                .in_data     (data_q[STAGES-1]),
                .out_valid   (skid_valid),
                .out_ready   (out_ready),
                .out_data    (skid_data),
                .count_nxt_c (skid_cnt_nxt)
            );

            assign tail_ready = skid_in_ready;
            assign out_valid  = skid_valid & ~flush_all;
            assign out_data   = skid_data;
        end else begin : g_noskid
            assign tail_ready   = out_ready;
            assign out_valid    = ev[STAGES-1] & ~flush_all;
            assign out_data     = data_q[STAGES-1];
            assign skid_cnt_nxt = '0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_elastic_chain.sv
// Directed bench: a 4-stage chain without skid and a 1-stage chain with skid buffer.
module tb_pipe_elastic_chain;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, flush_all, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [3:0]  flush, stage_valid;
    logic [2:0]  occupancy;

    logic        s_in_valid, s_in_ready, s_flush, s_flush_all, s_out_valid, s_out_ready;
    logic        s_stage_valid;
    logic [7:0]  s_in_data, s_out_data;
    logic [1:0]  s_occupancy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_elastic_chain #(.DATA_W(32), .STAGES(4), .SKID(1'b0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush), .flush_all(flush_all), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .stage_valid(stage_valid), .occupancy(occupancy)
    );

    pipe_elastic_chain #(.DATA_W(8), .STAGES(1), .SKID(1'b1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .flush(s_flush), .flush_all(s_flush_all),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .stage_valid(s_stage_valid), .occupancy(s_occupancy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic ordy);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
    endtask

    initial begin
        reset = 1'b1; flush = '0; flush_all = 1'b0;
        drive(1'b1, 32'h55, 1'b1);
        s_in_valid = 1'b0; s_in_data = '0; s_flush = 1'b0; s_flush_all = 1'b0; s_out_ready = 1'b0;

        // reset held two cycles with in_valid asserted
        for (int r = 0; r < 2; r++) begin
            tick();
            #2;
            check("rst_in_ready", in_ready, 1'b0);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_occupancy", occupancy, 3'd0);
            check("rst_stage_valid", stage_valid, 4'd0);
            check("rst_skid_occ", s_occupancy, 2'd0);
        end
        reset = 1'b0;
        in_valid = 1'b0;

        // back-to-back streaming 0x1..0x8, latency 4
        for (int k = 0; k < 13; k++) begin
            tick();
            drive(k < 8, 32'(k + 1), 1'b1);
            #2;
            check("stream_in_ready", in_ready, 1'b1);
            if (k >= 4 && k < 12) begin
                check("stream_out_valid", out_valid, 1'b1);
                check("stream_out_data", out_data, 32'(k - 3));
            end else begin
                check("stream_idle", out_valid, 1'b0);
            end
            if (k >= 4 && k <= 8) check("stream_occ", occupancy, 3'd4);
        end

        // backpressure: fill 0xA..0xD, stall 5 cycles, release
        for (int f = 0; f < 4; f++) begin
            tick();
            drive(1'b1, 32'hA + 32'(f), 1'b0);
            #2;
            check("bp_fill_ready", in_ready, 1'b1);
        end
        for (int h = 0; h < 5; h++) begin
            tick();
            drive(1'b1, 32'hEE, 1'b0);
            #2;
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_out_data", out_data, 32'hA);
            check("bp_occ", occupancy, 3'd4);
        end
        for (int r = 0; r < 5; r++) begin
            tick();
            drive(1'b0, 32'h0, 1'b1);
            #2;
            if (r < 4) begin
                check("bp_rel_valid", out_valid, 1'b1);
                check("bp_rel_data", out_data, 32'hA + 32'(r));
            end else begin
                check("bp_rel_empty", out_valid, 1'b0);
            end
        end

        // bubble collapse: 0x10, gap, 0x11 packed into stages 3,2
        tick(); drive(1'b1, 32'h10, 1'b0);
        tick(); drive(1'b0, 32'h0, 1'b0);
        tick(); drive(1'b1, 32'h11, 1'b0);
        tick(); drive(1'b0, 32'h0, 1'b0);
        tick(); drive(1'b0, 32'h0, 1'b0);
        tick(); drive(1'b1, 32'h12, 1'b0);
        #2;
        check("bub_stage_valid", stage_valid, 4'b1100);
        check("bub_occ", occupancy, 3'd2);
        check("bub_ready_a", in_ready, 1'b1);
        tick(); drive(1'b1, 32'h13, 1'b0);
        #2;
        check("bub_ready_b", in_ready, 1'b1);
        tick(); drive(1'b1, 32'hEE, 1'b0);
        #2;
        check("bub_full_ready", in_ready, 1'b0);
        check("bub_full_valid", stage_valid, 4'b1111);
        check("bub_full_occ", occupancy, 3'd4);
        for (int d = 0; d < 5; d++) begin
            tick();
            drive(1'b0, 32'h0, 1'b1);
            #2;
            if (d < 4) check("bub_drain", out_data, 32'h10 + 32'(d));
            else       check("bub_drain_empty", out_valid, 1'b0);
        end

        // per-stage flush 0110 over 0x20..0x23
        for (int f = 0; f < 4; f++) begin
            tick();
            drive(1'b1, 32'h20 + 32'(f), 1'b0);
        end
        tick();
        drive(1'b0, 32'h0, 1'b0);
        flush = 4'b0110;
        #2;
        check("fl_out_data", out_data, 32'h20);
        tick();
        flush = 4'b0000;
        drive(1'b0, 32'h0, 1'b1);
        #2;
        check("fl_stage_valid", stage_valid, 4'b1010);
        check("fl_occ", occupancy, 3'd2);
        check("fl_out_first", out_data, 32'h20);
        tick(); #2;
        check("fl_bubble", out_valid, 1'b0);
        tick(); #2;
        check("fl_out_second_v", out_valid, 1'b1);
        check("fl_out_second", out_data, 32'h23);
        tick(); #2;
        check("fl_out_done", out_valid, 1'b0);

        // flush_all mid-stall with in_valid high
        tick(); drive(1'b1, 32'h30, 1'b0);
        tick(); drive(1'b1, 32'h31, 1'b0);
        tick(); drive(1'b0, 32'h0, 1'b0);
        tick(); drive(1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 32'h99, 1'b1);
        flush_all = 1'b1;
        #2;
        check("fa_out_valid", out_valid, 1'b0);
        check("fa_in_ready", in_ready, 1'b0);
        tick();
        flush_all = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        #2;
        check("fa_occ", occupancy, 3'd0);
        check("fa_stage_valid", stage_valid, 4'd0);
        tick(); #2;
        check("fa_nothing_out", out_valid, 1'b0);

        // flush on the last stage while downstream is ready: item is not delivered
        tick(); drive(1'b1, 32'h40, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(); drive(1'b0, 32'h0, 1'b0);
        end
        tick();
        drive(1'b0, 32'h0, 1'b1);
        flush = 4'b1000;
        #2;
        check("fl3_out_valid", out_valid, 1'b0);
        tick();
        flush = 4'b0000;
        #2;
        check("fl3_occ", occupancy, 3'd0);
        check("fl3_out_after", out_valid, 1'b0);

        // skid chain: out_ready toggles each cycle over 16 items
        begin
            int         sent = 0;
            int         got = 0;
            logic [7:0] exp_d = 8'd1;
            logic       ir;
            for (int c = 0; c < 80 && got < 16; c++) begin
                tick();
                s_in_valid  = (sent < 16);
                s_in_data   = 8'(sent + 1);
                s_out_ready = ((c % 2) == 1);
                #2;
                ir = s_in_ready;
                s_out_ready = ~s_out_ready;
                #1;
                check("skid_ready_indep", s_in_ready, ir);
                s_out_ready = ~s_out_ready;
                #1;
                if (c == 1) check("skid_lat_early", s_out_valid, 1'b0);
                if (c == 2) begin
                    check("skid_lat_valid", s_out_valid, 1'b1);
                    check("skid_lat_data", s_out_data, 8'd1);
                end
                if (s_in_valid && s_in_ready) sent++;
                if (s_out_valid && s_out_ready) begin
                    check("skid_data", s_out_data, exp_d);
                    exp_d++;
                    got++;
                end
            end
            check("skid_count", 32'(got), 32'd16);
            tick();
            s_in_valid = 1'b0;
            #2;
            check("skid_end_occ", s_occupancy, 2'd0);
            check("skid_end_valid", s_out_valid, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
